// File: rtl/joypad_serializer.sv
// joypad_serializer
// Serialises NUM_PORTS controller button words onto the NES $4016/$4017
// read protocol. MODE selects the NES 8-bit report (0) or SNES 16-bit
// report (1). Everything runs in the NES clk domain.
//
// Optional feature macro: JOYPAD_TURBO_EN
//   Defined   - a shared free-running turbo counter/phase generates
//               autofire on A (from X) and B (from Y) in NES mode.
//   Undefined - no turbo registers exist; X/Y are ignored in NES mode.

module joypad_serializer #(
    parameter int NUM_PORTS  = 2,
    parameter int MODE       = 0,
    parameter int TURBO_HALF = 358000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    strobe,
    input  logic [NUM_PORTS-1:0]    ser_clk,
    input  logic [12*NUM_PORTS-1:0] btns,
    output logic [NUM_PORTS-1:0]    data_out
);

    localparam int REPORT_W = (MODE == 1) ? 16 : 8;
    localparam int CNT_W    = (TURBO_HALF > 1) ? $clog2(TURBO_HALF) : 1;

    // Per-port autofire contributions to report bits 0 (A) and 1 (B).
    logic [NUM_PORTS-1:0] auto_a;
    logic [NUM_PORTS-1:0] auto_b;

`ifdef JOYPAD_TURBO_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURBO_HALF - 1);

    logic [CNT_W-1:0] turbo_cnt_q;
    logic [CNT_W-1:0] turbo_cnt_d;
    logic             turbo_phase_q;
    logic             turbo_phase_d;

    // Counter wraps after TURBO_HALF cycles and flips the shared phase.
    always_comb begin
        turbo_cnt_d   = turbo_cnt_q + CNT_W'(1);
        turbo_phase_d = turbo_phase_q;
        if (turbo_cnt_q == CNT_LAST) begin
            turbo_cnt_d   = '0;
            turbo_phase_d = ~turbo_phase_q;
        end
    end

    // Turbo counter and phase registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            turbo_cnt_q   <= '0;
            turbo_phase_q <= 1'b0;
        end else begin
            turbo_cnt_q   <= turbo_cnt_d;
            turbo_phase_q <= turbo_phase_d;
        end
    end

    // X drives autofire A and Y drives autofire B, gated by the phase.
    always_comb begin
        auto_a = '0;
        auto_b = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            auto_a[p] = btns[12*p+8] & turbo_phase_q;
            auto_b[p] = btns[12*p+9] & turbo_phase_q;
        end
    end
`else
    assign auto_a = '0;
    assign auto_b = '0;
`endif

    // Some inputs are meaningless in a given build (X/Y without turbo in
    // NES mode, autofire in SNES mode); fold them away explicitly.
    logic inputs_unused;
    assign inputs_unused = ^{btns, auto_a, auto_b};

    // Builds one port's report word; bit 0 is shifted out first.
    function automatic logic [REPORT_W-1:0] build_report(
        input logic [11:0] b,
        input logic        aa,
        input logic        ab
    );
        logic [15:0] rep;
        if (MODE == 1) begin
            // B, Y, SELECT, START, UP, DOWN, LEFT, RIGHT, A, X, L, R, 0000
            rep = {4'h0, b[11], b[10], b[8], b[0], b[7:4], b[3], b[2], b[9], b[1]};
        end else begin
            // A, B, SELECT, START, UP, DOWN, LEFT, RIGHT
            rep = {8'h00, b[7:2], b[1] | ab, b[0] | aa};
        end
        return rep[REPORT_W-1:0];
    endfunction

    logic [NUM_PORTS-1:0][REPORT_W-1:0] sr_q;
    logic [NUM_PORTS-1:0][REPORT_W-1:0] sr_d;
    logic [NUM_PORTS-1:0]               prev_clk_q;
    logic [NUM_PORTS-1:0]               prev_clk_d;
    logic [NUM_PORTS-1:0]               fall;

    // Falling-edge detect on each read clock against last cycle's value.
    always_comb begin
        prev_clk_d = ser_clk;
        fall       = prev_clk_q & ~ser_clk;
    end

    // Strobe reloads every cycle and beats a simultaneous read edge;
    // otherwise a read edge shifts right with 1s entering at the top,
    // which is what makes over-reads return 1 forever.
    always_comb begin
        sr_d = sr_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (strobe) begin
                sr_d[p] = build_report(btns[12*p +: 12], auto_a[p], auto_b[p]);
            end else if (fall[p]) begin
                sr_d[p] = {1'b1, sr_q[p][REPORT_W-1:1]};
            end
        end
    end

    // Shift and edge registers; reset leaves every line reading 1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sr_q       <= '1;
            prev_clk_q <= '0;
        end else begin
            sr_q       <= sr_d;
            prev_clk_q <= prev_clk_d;
        end
    end

    // Serial output is the registered bit 0 of each port's shift register.
    always_comb begin
        data_out = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            data_out[p] = sr_q[p][0];
        end
    end

endmodule

// File: tb/tb_joypad_serializer.sv
// tb_joypad_serializer
// Directed bench for joypad_serializer. Two instances share all inputs:
// an NES-mode one and an SNES-mode one, both with a short turbo period.
// Turbo expectations switch on JOYPAD_TURBO_EN.

module tb_joypad_serializer;

    logic        clk;
    logic        resetn;
    logic        strobe;
    logic [1:0]  ser_clk;
    logic [23:0] btns;
    logic [1:0]  nes_out;
    logic [1:0]  snes_out;

    int vector_count = 0;
    int miss_count   = 0;
    int cycle_count;

    joypad_serializer #(.NUM_PORTS(2), .MODE(0), .TURBO_HALF(4)) dut_nes (
        .clk      (clk),
        .resetn   (resetn),
        .strobe   (strobe),
        .ser_clk  (ser_clk),
        .btns     (btns),
        .data_out (nes_out)
    );

    joypad_serializer #(.NUM_PORTS(2), .MODE(1), .TURBO_HALF(4)) dut_snes (
        .clk      (clk),
        .resetn   (resetn),
        .strobe   (strobe),
        .ser_clk  (ser_clk),
        .btns     (btns),
        .data_out (snes_out)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts clock edges since reset release; turbo phase derives from it.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cycle_count <= 0;
        else         cycle_count <= cycle_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vector_count++;
        if (got !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Presents buttons and pulses strobe for one cycle.
    task automatic applyStimulus(input logic [23:0] b);
        btns   = b;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        @(negedge clk);
    endtask

    // Samples the current bit, then clocks one falling edge on a port.
    task automatic readBit(input int port, output logic [1:0] nes_v, output logic [1:0] snes_v);
        nes_v  = nes_out;
        snes_v = snes_out;
        ser_clk[port] = 1'b0;
        @(negedge clk);
        ser_clk[port] = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [1:0]  n;
        logic [1:0]  s;
        logic [7:0]  nes_pat;
        logic [15:0] snes_pat;
        int          load_k;
        int          exp_bit;

        resetn  = 1'b0;
        strobe  = 1'b0;
        ser_clk = 2'b11;
        btns    = '0;
        waitCycles(3);
        checkOutput("reset_nes", nes_out, 2'b11);
        checkOutput("reset_snes", snes_out, 2'b11);

        resetn = 1'b1;
        waitCycles(2);
        checkOutput("idle_nes", nes_out, 2'b11);

        // Reads with no prior load only ever see 1s.
        for (int i = 0; i < 20; i++) begin
            readBit(0, n, s);
            checkOutput($sformatf("noload_rd%0d", i), n[0], 1'b1);
        end

        // NES report: A and START on port 0; port 1 holds A and must not shift.
        nes_pat = 8'b0000_1001;
        applyStimulus({12'h001, 12'h009});
        for (int i = 0; i < 11; i++) begin
            readBit(0, n, s);
            checkOutput($sformatf("nes_rd%0d", i), n[0], (i < 8) ? nes_pat[i] : 1'b1);
            checkOutput($sformatf("nes_p1_%0d", i), n[1], 1'b1);
        end

        // SNES report: A, L, R on port 0.
        snes_pat = 16'h0D00;
        applyStimulus({12'h000, 12'hC01});
        for (int i = 0; i < 18; i++) begin
            readBit(0, n, s);
            checkOutput($sformatf("snes_rd%0d", i), s[0], (i < 16) ? snes_pat[i] : 1'b1);
        end
        checkOutput("snes_p1", s[1], 1'b0);

        // Load beats a falling edge in the same cycle.
        btns   = {12'h000, 12'h001};
        strobe = 1'b1;
        @(negedge clk);
        ser_clk[0] = 1'b0;
        @(negedge clk);
        checkOutput("load_wins", nes_out[0], 1'b1);
        ser_clk[0] = 1'b1;
        btns       = 24'h000000;
        @(negedge clk);
        checkOutput("strobe_live", nes_out[0], 1'b0);
        strobe = 1'b0;
        @(negedge clk);

        // Reset in the middle of a read.
        applyStimulus({12'h001, 12'h001});
        for (int i = 0; i < 3; i++) readBit(0, n, s);
        checkOutput("pre_reset", nes_out[0], 1'b0);
        #2 resetn = 1'b0;
        #1;
        checkOutput("async_reset_nes", nes_out, 2'b11);
        checkOutput("async_reset_snes", snes_out, 2'b11);
        @(negedge clk);
        resetn = 1'b1;
        waitCycles(3);
        checkOutput("post_reset_idle", nes_out, 2'b11);
        applyStimulus({12'h000, 12'h002});
        readBit(0, n, s);
        checkOutput("b_rd0", n[0], 1'b0);
        readBit(0, n, s);
        checkOutput("b_rd1", n[0], 1'b1);

        // Turbo on A via X on port 1, strobe held so bit 0 tracks the phase.
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        btns   = {12'h100, 12'h000};
        strobe = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
`ifdef JOYPAD_TURBO_EN
            exp_bit = ((cycle_count - 1) / 4) % 2;
`else
            exp_bit = 0;
`endif
            checkOutput($sformatf("turbo_x%0d", i), nes_out[1], exp_bit);
        end
        strobe = 1'b0;
        @(negedge clk);

        // Turbo on B via Y on port 1, sampled from separate strobes.
        btns = {12'h200, 12'h000};
        for (int i = 0; i < 4; i++) begin
            strobe = 1'b1;
            @(negedge clk);
            load_k = cycle_count;
            strobe = 1'b0;
            @(negedge clk);
`ifdef JOYPAD_TURBO_EN
            exp_bit = ((load_k - 1) / 4) % 2;
`else
            exp_bit = 0;
`endif
            readBit(1, n, s);
            checkOutput($sformatf("turbo_y_a%0d", i), n[1], 1'b0);
            readBit(1, n, s);
            checkOutput($sformatf("turbo_y_b%0d", i), n[1], exp_bit);
            waitCycles(i + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule
